// File: rtl/fip_pkg.sv
// fip_pkg: shared layer encodings, fault configuration record and lane rotate helper.
package fip_pkg;
    localparam logic [1:0] LAYER_IN = 2'd0;
    localparam logic [1:0] LAYER_A  = 2'd1;
    localparam logic [1:0] LAYER_B  = 2'd2;
    localparam logic [1:0] LAYER_C  = 2'd3;

    // bit_idx is wide enough for any legal WIDTH; indices >= WIDTH never match a lane
    typedef struct packed {
        logic       en;
        logic [1:0] layer;
        logic [6:0] bit_idx;
        logic       val;
    } fault_cfg_t;

    function automatic logic [63:0] rotl_k(input logic [63:0] v, input int w, input int k);
        rotl_k = '0;
        for (int i = 0; i < 64; i++)
            if (i < w) rotl_k[i] = v[(i + k) % w];
    endfunction
endpackage

// File: rtl/fip_misr.sv
// fip_misr: multiple-input signature register with saturating vector counter; clear beats compaction.
module fip_misr #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(16'h002D),
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_sig,
    output logic [CNT_W-1:0] o_cnt
);
    logic [WIDTH-1:0] r_sig;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_sig <= '0;
            r_cnt <= '0;
        end else if (i_en) begin
            r_sig <= {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ i_data;
            r_cnt <= (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
        end
    end

    assign o_sig = r_sig;
    assign o_cnt = r_cnt;
endmodule

// File: rtl/fault_inject_pipe.sv
// fault_inject_pipe: three-stage gate-cone pipeline with a single stuck-at fault
// override on any layer/lane, valid/ready streaming and MISR output compaction.
module fault_inject_pipe
    import fip_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] MISR_POLY = WIDTH'(16'h002D),
    parameter int               CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     cfg_load,
    output logic                     cfg_ready,
    input  logic                     fault_en,
    input  logic [1:0]               fault_layer,
    input  logic [$clog2(WIDTH)-1:0] fault_bit,
    input  logic                     fault_val,
    input  logic                     sig_clr,
    output logic [WIDTH-1:0]         signature,
    output logic [CNT_W-1:0]         vec_cnt
);
    fault_cfg_t       r_cfg;
    logic             r_v1, r_v2, r_v3;
    logic [WIDTH-1:0] r_x1, r_b2, r_out;
    logic             w_stall;
    logic [WIDTH-1:0] w_x_raw, w_a_raw, w_b_raw, w_c_raw;
    logic [WIDTH-1:0] w_x, w_a, w_b, w_c;

    assign w_stall   = r_v3 & ~out_ready;
    assign in_ready  = ~w_stall;
    assign cfg_ready = ~(r_v1 | r_v2 | r_v3 | in_valid);
    assign out_valid = r_v3;
    assign out_data  = r_out;

    assign w_x_raw = in_data;
    assign w_a_raw = r_x1 & ~WIDTH'(rotl_k(64'(r_x1), WIDTH, 1));
    assign w_b_raw = ~(w_a & WIDTH'(rotl_k(64'(r_x1), WIDTH, 2)));
    assign w_c_raw = ~(r_b2 ^ WIDTH'(rotl_k(64'(r_b2), WIDTH, 1)));

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic w_hit;
        assign w_hit  = r_cfg.en && (r_cfg.bit_idx == 7'(i));
        assign w_x[i] = (w_hit && r_cfg.layer == LAYER_IN) ? r_cfg.val : w_x_raw[i];
        assign w_a[i] = (w_hit && r_cfg.layer == LAYER_A)  ? r_cfg.val : w_a_raw[i];
        assign w_b[i] = (w_hit && r_cfg.layer == LAYER_B)  ? r_cfg.val : w_b_raw[i];
        assign w_c[i] = (w_hit && r_cfg.layer == LAYER_C)  ? r_cfg.val : w_c_raw[i];
    end

    // every stage freezes together while the consumer back-pressures
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg <= '0;
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_x1  <= '0;
            r_b2  <= '0;
            r_out <= '0;
        end else begin
            if (cfg_load && cfg_ready)
                r_cfg <= '{en: fault_en, layer: fault_layer, bit_idx: 7'(fault_bit), val: fault_val};
            if (!w_stall) begin
                r_v1  <= in_valid;
                r_x1  <= w_x;
                r_v2  <= r_v1;
                r_b2  <= w_b;
                r_v3  <= r_v2;
                r_out <= w_c;
            end
        end
    end

    fip_misr #(.WIDTH(WIDTH), .POLY(MISR_POLY), .CNT_W(CNT_W)) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (sig_clr),
        .i_en  (r_v3 & out_ready),
        .i_data(r_out),
        .o_sig (signature),
        .o_cnt (vec_cnt)
    );
endmodule
